// File: rtl/store_align_unit_pkg.sv
// Shared store-type codes, byte masks and FSM encoding for the store alignment path.
package store_align_unit_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;
  localparam logic [1:0] ST_RSV = 2'b11;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE0 = 2'd1,
    S_ISSUE1 = 2'd2
  } state_t;

  // Reserved type yields an empty mask, so it never reports a split.
  function automatic logic [3:0] type_mask(input logic [1:0] st_type);
    case (st_type)
      ST_SB:   type_mask = MASK_B;
      ST_SH:   type_mask = MASK_H;
      ST_SW:   type_mask = MASK_W;
      default: type_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_align_unit_lane_gen.sv
// Combinational byte-lane placement over a two-word window: be8 and lane-positioned d64.
// store_byte_lane handles one of the eight window lanes.
module store_byte_lane (
  input  logic [2:0]       lane,
  input  logic [1:0]       off,
  input  logic [7:0]       be8,
  input  logic [3:0][7:0]  src,
  output logic [7:0]       dout
);
  logic [2:0] idx;

  assign idx  = lane - {1'b0, off};
  assign dout = be8[lane] ? src[idx[1:0]] : 8'h00;
endmodule

module store_lane_gen
  import store_align_unit_pkg::*;
#(
  parameter int NUM_LANES = 2 * WORD_BYTES
) (
  input  logic [1:0]                 off,
  input  logic [1:0]                 st_type,
  input  logic [8*WORD_BYTES-1:0]    data,
  output logic [NUM_LANES-1:0]       be8,
  output logic [8*NUM_LANES-1:0]     d64
);
  logic [WORD_BYTES-1:0][7:0] src;
  logic [NUM_LANES-1:0][7:0]  lanes;

  assign src = data;
  assign be8 = {{(NUM_LANES-WORD_BYTES){1'b0}}, type_mask(st_type)} << off;
  assign d64 = lanes;

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    store_byte_lane u_lane (
      .lane (3'(j)),
      .off  (off),
      .be8  (be8),
      .src  (src),
      .dout (lanes[j])
    );
  end
endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: turns one store request into one or two aligned memory writes.
// Build option MISALIGN_SPLIT_EN enables word-crossing stores; otherwise they raise store_err.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_type,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              store_err
);
  state_t        state;
  logic [7:0]    be8;
  logic [63:0]   d64;
  logic          split;
  logic          accept;

  store_lane_gen u_lane_gen (
    .off     (req_addr[1:0]),
    .st_type (req_type),
    .data    (req_data),
    .be8     (be8),
    .d64     (d64)
  );

  assign split     = |be8[7:4];
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef MISALIGN_SPLIT_EN
  logic          split_q;
  logic [3:0]    hi_be;
  logic [31:0]   hi_data;
`else
  logic          unused_hi;
  assign unused_hi = ^d64[63:32];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      store_err <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      split_q   <= 1'b0;
      hi_be     <= '0;
      hi_data   <= '0;
`endif
    end else begin
      store_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (req_type == ST_RSV)
              store_err <= 1'b1;
`ifndef MISALIGN_SPLIT_EN
            else if (split)
              store_err <= 1'b1;
`endif
            else begin
              state     <= S_ISSUE0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be8[3:0];
              mem_wdata <= d64[31:0];
`ifdef MISALIGN_SPLIT_EN
              split_q   <= split;
              hi_be     <= be8[7:4];
              hi_data   <= d64[63:32];
`endif
            end
          end
        end
        S_ISSUE0: begin
          if (mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
            if (split_q) begin
              // Second half goes to the next word; address wraps at the top of memory.
              state     <= S_ISSUE1;
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_be    <= hi_be;
              mem_wdata <= hi_data;
            end else
`endif
            begin
              state     <= S_IDLE;
              mem_valid <= 1'b0;
              mem_addr  <= '0;
              mem_be    <= '0;
              mem_wdata <= '0;
            end
          end
        end
`ifdef MISALIGN_SPLIT_EN
        S_ISSUE1: begin
          if (mem_ready) begin
            state     <= S_IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          mem_valid <= 1'b0;
          mem_addr  <= '0;
          mem_be    <= '0;
          mem_wdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
Store-side counterpart to the load data-extension path. It takes one store request (address, register data, store width) from the MEM stage and generates word-aligned Data Memory writes with per-byte write enables. A store that crosses a word boundary is split into two sequential aligned writes, and the pipeline is stalled while the unit is busy.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, memory word width (fixed at 32; the byte-enable width is DATA_W/8 = 4)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  store request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_addr  in  ADDR_W  byte address of the store
req_data  in  DATA_W  source register value, right-aligned
req_type  in  2  store width, encoded as ST_SB/ST_SH/ST_SW/ST_RSV
mem_valid  out  1  memory write request
mem_ready  in  1  memory accepts the write this cycle
mem_addr  out  ADDR_W  word address; bits [1:0] always 0
mem_be  out  4  byte write enables; bit i enables byte lane [8i+7:8i]
mem_wdata  out  DATA_W  lane-positioned write data
busy  out  1  state != IDLE; drives the pipeline stall
store_err  out  1  one-cycle error pulse

Behaviour:
- Reset (asynchronous, rst_n=0): state = IDLE; mem_valid, mem_addr, mem_be, mem_wdata, store_err, busy all 0; req_ready = 1. Any pending request or second half is dropped.
- States: IDLE, ISSUE0, ISSUE1.
- Accept: a request is accepted when req_valid && req_ready. At acceptance the unit registers:
  - off = req_addr[1:0]
  - base = {req_addr[ADDR_W-1:2], 2'b00}
  - mask = 0001 for SB, 0011 for SH, 1111 for SW
  - be8 = {4'b0, mask} << off
  - d64 = {32'b0, req_data} << (8*off)
  - split = |be8[7:4]
- IDLE -> ISSUE0 on accept with a valid type and a legal split. All outputs are registered.
- ISSUE0 outputs: mem_valid=1, mem_addr=base, mem_be=be8[3:0], mem_wdata=d64[31:0].
- ISSUE0 -> ISSUE1 when mem_ready && split. ISSUE0 -> IDLE when mem_ready && !split.
- ISSUE1 outputs: mem_valid=1, mem_addr=base+4 (wraps modulo 2^ADDR_W, so 0xFFFFFFFC+4 = 0x00000000), mem_be=be8[7:4], mem_wdata=d64[63:32]. ISSUE1 -> IDLE on mem_ready.
- Holding: while mem_ready=0, all mem_* outputs stay stable. mem_valid never drops without mem_ready.
- Lanes that are not enabled in mem_wdata carry 0.
- Latency:
  - aligned store: first mem_valid in the cycle after accept; the unit returns to IDLE the cycle after mem_ready.
  - split store: minimum 2 memory cycles.
- ST_RSV: the request is accepted, no memory write is issued, store_err pulses in the cycle after accept, and the state stays IDLE.
- Back-to-back: req_ready rises in the cycle after the final mem_ready, so a new request can be accepted in that cycle.
- mem_valid is 0 whenever state = IDLE.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined: split stores are performed as described above.
- Undefined: a request with split=1 is accepted and discarded, with no mem_valid. store_err pulses in the cycle after accept, state stays IDLE, and ISSUE1 is unreachable (it may be optimised away). Non-split stores behave identically in both builds.

Decomposition:
- Shared package (extend Parameters.v): store-type constants ST_SB=2'b00, ST_SH=2'b01, ST_SW=2'b10, ST_RSV=2'b11; state encodings; mask constants.
- One natural sub-module: store_lane_gen. It is combinational and computes be8 and d64 from off, type and data, and is reused by the registering stage.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, mem_ready=1 -> one write: addr 0x100, be 1111, wdata 0xDEADBEEF; busy for 1 cycle.
- SB addr 0x103, data 0x000000AB -> addr 0x100, be 1000, wdata 0xAB000000.
- SH addr 0x103, data 0x00001234, macro defined -> first write: addr 0x100, be 1000, wdata 0x34000000; second write: addr 0x104, be 0001, wdata 0x00000012.
- SW addr 0xFFFFFFFE, data 0xDEADBEEF, macro defined -> first write: 0xFFFFFFFC, be 1100, wdata 0xBEEF0000; second write: 0x00000000, be 0011, wdata 0x0000DEAD. Undefined build: no write, store_err one-cycle pulse.
- SW addr 0x200 with mem_ready held low 3 cycles -> mem_* outputs stable for all 4 cycles; the unit returns to IDLE after mem_ready.
- rst_n low while in ISSUE1 -> all outputs 0 immediately and req_ready=1 while in reset; after release there is no second write and the next request is accepted normally.
